// File: rtl/result_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | result_streamer                                                          |
// | Scans the 1-bit result memory row-major, packs 8 pixels per byte (LSB =  |
// | leftmost) and streams bytes on a valid/ready interface.                  |
// | Optional macro STREAM_HEADER_EN prepends 0xA5, WIDTH_BITS, HEIGHT_BITS.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module result_streamer #(
  parameter int         WIDTH_BITS  = 8,
  parameter int         HEIGHT_BITS = 8,
  parameter logic [2:0] RUN_STATE   = 3'd3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0]             global_state,
  output logic [WIDTH_BITS-1:0]  oResultCol,
  output logic [HEIGHT_BITS-1:0] oResultRow,
  input  logic                   iResultData,
  output logic [7:0]             oByte,
  output logic                   oValid,
  input  logic                   iReady,
  output logic                   finished
);

  // Column position is kept as a byte index; a 1-bit index stays 0 when the row is one byte.
  localparam int             CB        = (WIDTH_BITS > 3) ? WIDTH_BITS - 3 : 1;
  localparam logic [CB-1:0]  COLB_LAST = CB'((1 << (WIDTH_BITS - 3)) - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
`ifdef STREAM_HEADER_EN
  localparam logic [2:0] S_HEADER = 3'd1;
`endif
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_SEND   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]             state, state_nxt;
  logic [3:0]             bit_cnt;
  logic [2:0]             bit_idx;
  logic [CB-1:0]          colb, colb_nxt;
  logic [HEIGHT_BITS-1:0] row, row_nxt;
  logic [7:0]             pack;
  logic                   run, xfer, col_last, last_byte;
`ifdef STREAM_HEADER_EN
  logic [1:0]             hdr_cnt;
`endif

  assign run       = (global_state == RUN_STATE);
  assign xfer      = oValid & iReady;
  assign col_last  = (colb == COLB_LAST);
  assign last_byte = col_last && (&row);
  assign bit_idx   = 3'(bit_cnt - 4'd1);
  assign colb_nxt  = col_last ? '0 : colb + CB'(1);
  assign row_nxt   = col_last ? row + HEIGHT_BITS'(1) : row;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef STREAM_HEADER_EN
      S_IDLE:   if (run) state_nxt = S_HEADER;
      S_HEADER: if (xfer && hdr_cnt == 2'd2) state_nxt = S_FETCH;
`else
      S_IDLE:   if (run) state_nxt = S_FETCH;
`endif
      S_FETCH:  if (bit_cnt == 4'd8) state_nxt = S_SEND;
      S_SEND:   if (xfer) state_nxt = last_byte ? S_DONE : S_FETCH;
      S_DONE:   if (!run) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    oValid   = (state == S_SEND);
`ifdef STREAM_HEADER_EN
    oValid   = oValid || (state == S_HEADER);
`endif
    oByte    = oValid ? pack : 8'd0;
    finished = (state == S_DONE);
  end

  // Address registers are loaded on the edge that enters FETCH so cycle 0 already shows base.
  always_ff @(posedge clock) begin
    if (reset) begin
      colb       <= '0;
      row        <= '0;
      bit_cnt    <= 4'd0;
      pack       <= 8'd0;
      oResultCol <= '0;
      oResultRow <= '0;
`ifdef STREAM_HEADER_EN
      hdr_cnt    <= 2'd0;
`endif
    end else begin
      case (state)
        S_IDLE: if (run) begin
          bit_cnt    <= 4'd0;
          oResultCol <= WIDTH_BITS'({colb, 3'b000});
          oResultRow <= row;
`ifdef STREAM_HEADER_EN
          pack       <= 8'hA5;
          hdr_cnt    <= 2'd0;
`endif
        end
`ifdef STREAM_HEADER_EN
        S_HEADER: if (xfer) begin
          hdr_cnt <= hdr_cnt + 2'd1;
          if (hdr_cnt == 2'd0)      pack <= 8'(WIDTH_BITS);
          else if (hdr_cnt == 2'd1) pack <= 8'(HEIGHT_BITS);
        end
`endif
        S_FETCH: begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt != 4'd0) pack[bit_idx] <= iResultData;
          if (bit_cnt < 4'd7)  oResultCol <= oResultCol + WIDTH_BITS'(1);
        end
        S_SEND: if (xfer) begin
          colb    <= colb_nxt;
          row     <= row_nxt;
          bit_cnt <= 4'd0;
          if (!last_byte) begin
            oResultCol <= WIDTH_BITS'({colb_nxt, 3'b000});
            oResultRow <= row_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_streamer.sv
`default_nettype none
// Randomised bench for result_streamer: RAM model with 1-cycle latency, expected byte
// stream built from the pixel image, handshake stability and reset/state-control checks.
module tb_result_streamer;
  localparam int WB    = 5;
  localparam int HB    = 4;
  localparam int W     = 1 << WB;
  localparam int H     = 1 << HB;
  localparam int LIMIT = 8000;

  logic          clock, reset, iResultData, iReady, oValid, finished;
  logic [2:0]    global_state;
  logic [WB-1:0] oResultCol;
  logic [HB-1:0] oResultRow;
  logic [7:0]    oByte;

  logic       pix [H][W];
  logic [7:0] exp_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  result_streamer #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .RUN_STATE(3'd3)) dut (
    .clock(clock), .reset(reset), .global_state(global_state),
    .oResultCol(oResultCol), .oResultRow(oResultRow), .iResultData(iResultData),
    .oByte(oByte), .oValid(oValid), .iReady(iReady), .finished(finished)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) iResultData <= pix[oResultRow][oResultCol];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic fill(input int pattern);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pattern)
          0:       pix[r][c] = 1'b1;
          1:       pix[r][c] = c[0];
          2:       pix[r][c] = (c == 0);
          default: pix[r][c] = 1'($urandom_range(1));
        endcase
  endtask

  task automatic build_expected();
    exp_q.delete();
`ifdef STREAM_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(WB));
    exp_q.push_back(8'(HB));
`endif
    for (int r = 0; r < H; r++)
      for (int b = 0; b < W / 8; b++) begin
        logic [7:0] v;
        v = 8'd0;
        for (int i = 0; i < 8; i++) v[i] = pix[r][8 * b + i];
        exp_q.push_back(v);
      end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check({tag, "_valid"}, 32'(oValid), 32'd0);
    check({tag, "_byte"}, 32'(oByte), 32'd0);
    check({tag, "_finished"}, 32'(finished), 32'd0);
    check({tag, "_col"}, 32'(oResultCol), 32'd0);
    check({tag, "_row"}, 32'(oResultRow), 32'd0);
    reset = 1'b0;
  endtask

  // Streams until finished (or stop_at transfers); drops global_state at drop_at transfers.
  task automatic run_stream(input int pct, input int stop_at, input int drop_at, output int got);
    int         guard;
    logic       prev_hold;
    logic [7:0] prev_b;
    got = 0;
    guard = 0;
    prev_hold = 1'b0;
    prev_b = 8'd0;
    forever begin
      @(negedge clock);
      if (prev_hold) begin
        check("hold_valid", 32'(oValid), 32'd1);
        check("hold_byte", 32'(oByte), 32'(prev_b));
      end
      if (finished) break;
      if (stop_at >= 0 && got == stop_at) break;
      if (drop_at >= 0 && got == drop_at) global_state = 3'd0;
      guard++;
      if (guard > LIMIT) begin
        check("finished_timeout", 32'(finished), 32'd1);
        break;
      end
      iReady = ($urandom_range(99) < pct);
      if (oValid && iReady) begin
        if (got < exp_q.size()) check($sformatf("byte%0d", got), 32'(oByte), 32'(exp_q[got]));
        else                    check("overrun", 32'(got), 32'(exp_q.size() - 1));
        got++;
      end
      prev_hold = oValid && !iReady;
      prev_b = oByte;
    end
  endtask

  task automatic end_checks(input string tag, input int got);
    check({tag, "_count"}, 32'(got), 32'(exp_q.size()));
    check({tag, "_finished"}, 32'(finished), 32'd1);
    check({tag, "_done_valid"}, 32'(oValid), 32'd0);
  endtask

  initial begin
    int got;
    reset = 1'b1;
    iReady = 1'b0;
    global_state = 3'd3;
    fill(0);
    build_expected();
    repeat (3) @(posedge clock);

    // All-ones image, always ready
    do_reset("rst_init");
    run_stream(100, -1, -1, got);
    end_checks("ones", got);

    // Alternating columns, then leftmost-column-only
    fill(1);
    build_expected();
    do_reset("rst_alt");
    run_stream(100, -1, -1, got);
    end_checks("alt", got);
    fill(2);
    build_expected();
    do_reset("rst_col0");
    run_stream(100, -1, -1, got);
    end_checks("col0", got);

    // Random image with sparse ready; global_state drops mid-stream but the stream completes
    fill(3);
    build_expected();
    do_reset("rst_rand");
    run_stream(30, -1, 10, got);
    end_checks("rand", got);
    @(negedge clock);
    check("rand_idle_finished", 32'(finished), 32'd0);

    // Reset mid-stream, then the restart resends from byte 0
    global_state = 3'd3;
    do_reset("rst_pre_mid");
    run_stream(60, 20, -1, got);
    check("mid_reached", 32'(got), 32'd20);
    do_reset("rst_mid");
    run_stream(60, -1, -1, got);
    end_checks("restart", got);

    // Outside RUN_STATE nothing moves; in DONE finished holds until the state changes
    global_state = 3'd2;
    do_reset("rst_wait");
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      iReady = 1'($urandom_range(1));
      check("wait_valid", 32'(oValid), 32'd0);
      check("wait_col", 32'(oResultCol), 32'd0);
      check("wait_row", 32'(oResultRow), 32'd0);
    end
    global_state = 3'd3;
    run_stream(50, -1, -1, got);
    end_checks("wait_run", got);
    repeat (5) begin
      @(negedge clock);
      check("done_hold", 32'(finished), 32'd1);
      check("done_valid", 32'(oValid), 32'd0);
    end
    global_state = 3'd0;
    @(negedge clock);
    check("done_exit", 32'(finished), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
